// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_seq_pkg;

    localparam int unsigned DIV_DATA_LEN = 8;

    // Counter must hold the value DATA_LEN itself.
    function automatic int unsigned div_cnt_width(input int unsigned data_len);
        return $clog2(data_len + 1);
    endfunction

    localparam int unsigned DIV_CNT_W = div_cnt_width(DIV_DATA_LEN);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    // M-extension ops served by this unit.
    typedef enum logic [1:0] {
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } div_alu_op_e;

    function automatic logic div_op_is_signed(input div_alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic div_op_wants_rem(input div_alu_op_e op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Operand/result handshake bundle for div_seq.
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_LEN = DIV_DATA_LEN
) ();

    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] dividend;
    logic [DATA_LEN-1:0] divisor;
    logic                is_signed;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] quotient;
    logic [DATA_LEN-1:0] remainder;
    logic                div_by_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtractor a - b as a + ~b + 1 with generate/propagate carries.
module div_trial_sub
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DATA_LEN + 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a_i & ~b_i;
    assign prop = a_i ^ ~b_i;

    // Carry chain; the +1 enters as carry-in.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign diff_o   = prop ^ carry[WIDTH-1:0];
    assign borrow_o = ~carry[WIDTH];

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider: one quotient bit per cycle, valid/ready on both sides.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_LEN = DIV_DATA_LEN
) (
    input logic      clk,
    input logic      rst,
    div_seq_if.slave bus
);

    localparam int unsigned CNT_W = div_cnt_width(DATA_LEN);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_LEN:0]   rem_q, rem_d;
    logic [DATA_LEN-1:0] quo_q, quo_d;
    logic [DATA_LEN-1:0] dvs_q, dvs_d;
    logic                sgn_quo_q, sgn_quo_d;
    logic                sgn_rem_q, sgn_rem_d;
    logic [DATA_LEN-1:0] quotient_q, quotient_d;
    logic [DATA_LEN-1:0] remainder_q, remainder_d;
    logic                dbz_q, dbz_d;

    logic [2*DATA_LEN:0] pair_sh;
    logic [DATA_LEN:0]   rem_sh;
    logic [DATA_LEN-1:0] quo_sh;
    logic [DATA_LEN:0]   trial;
    logic                borrow;
    logic [DATA_LEN:0]   rem_n;
    logic [DATA_LEN-1:0] quo_n;

    function automatic logic [DATA_LEN-1:0] mag(input logic [DATA_LEN-1:0] x, input logic sgn);
        return (sgn && x[DATA_LEN-1]) ? -x : x;
    endfunction

    // The remainder occupies the upper DATA_LEN+1 bits, the quotient the lower DATA_LEN.
    assign pair_sh = {rem_q, quo_q} << 1;
    assign rem_sh  = pair_sh[2*DATA_LEN:DATA_LEN];
    assign quo_sh  = pair_sh[DATA_LEN-1:0];

    div_trial_sub #(
        .WIDTH (DATA_LEN + 1)
    ) u_trial (
        .a_i      (rem_sh),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial),
        .borrow_o (borrow)
    );

    assign rem_n = borrow ? rem_sh : trial;
    assign quo_n = {quo_sh[DATA_LEN-1:1], ~borrow};

    // Next-state, datapath and result selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sgn_quo_d   = sgn_quo_q;
        sgn_rem_d   = sgn_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        state_d     = DIV_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = DIV_CALC;
                        rem_d     = '0;
                        quo_d     = mag(bus.dividend, bus.is_signed);
                        dvs_d     = mag(bus.divisor, bus.is_signed);
                        sgn_quo_d = bus.is_signed & (bus.dividend[DATA_LEN-1] ^ bus.divisor[DATA_LEN-1]);
                        sgn_rem_d = bus.is_signed & bus.dividend[DATA_LEN-1];
                        cnt_d     = CNT_W'(DATA_LEN);
                        dbz_d     = 1'b0;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q - 1'b1;
                // Final iteration: sign fix-up feeds the result registers directly.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DIV_DONE;
                    quotient_d  = sgn_quo_q ? -quo_n : quo_n;
                    remainder_d = sgn_rem_q ? -rem_n[DATA_LEN-1:0] : rem_n[DATA_LEN-1:0];
                end
            end
            DIV_DONE: begin
                if (bus.out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sgn_quo_q   <= 1'b0;
            sgn_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sgn_quo_q   <= sgn_quo_d;
            sgn_rem_q   <= sgn_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == DIV_IDLE);
    assign bus.out_valid   = (state_q == DIV_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (DATA_LEN = 8).
module tb_div_seq;

    localparam int unsigned DL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.DATA_LEN(DL)) bus ();

    div_seq #(.DATA_LEN(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: plain integer division with C-style truncation toward zero.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] q, output logic [7:0] r, output logic z);
        int sa, sb;
        if (b == 8'h00) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
            return;
        end
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        q  = 8'(sa / sb);
        r  = 8'(sa % sb);
        z  = 1'b0;
    endfunction

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    // Cycle count where the accept edge ends cycle 0.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'h00 ||
            bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h z=%b required 1 0 00 00 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        logic       ts [8];
        logic [7:0] tq [8];
        logic [7:0] tr [8];
        logic       tz [8];
        int         tl [8];
        int lat;
        ta = '{8'h64, 8'h9C, 8'h64, 8'h55, 8'h55, 8'h80, 8'h80, 8'hFF};
        tb = '{8'h07, 8'h07, 8'hF9, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01};
        ts = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        tq = '{8'h0E, 8'hF2, 8'hF2, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'hFF};
        tr = '{8'h02, 8'hFE, 8'h02, 8'h55, 8'h55, 8'h00, 8'h80, 8'h00};
        tz = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        tl = '{9,     9,     9,     1,     1,     9,     9,     9};
        for (int i = 0; i < 8; i++) begin
            send_op(ta[i], tb[i], ts[i]);
            wait_valid(lat);
            checks++;
            if (bus.quotient !== tq[i] || bus.remainder !== tr[i] || bus.div_by_zero !== tz[i]) begin
                errors++;
                $display("FAIL directed[%0d] %h/%h s=%b: got q=%h r=%h z=%b required q=%h r=%h z=%b",
                         i, ta[i], tb[i], ts[i], bus.quotient, bus.remainder, bus.div_by_zero,
                         tq[i], tr[i], tz[i]);
            end
            checks++;
            if (lat != tl[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, tl[i]);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send_op(8'h64, 8'h07, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 8'h11;
            bus.divisor  = 8'h01;
            bus.is_signed = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'h0E ||
                bus.remainder !== 8'h02 || bus.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b q=%h r=%h z=%b required 1 0 0e 02 0",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_ready: in_ready=%b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        send_op(8'hFF, 8'h10, 1'b0);
        wait_valid(lat);
        checks++;
        if (bus.quotient !== 8'h0F || bus.remainder !== 8'h0F || bus.div_by_zero !== 1'b0 || lat != 9) begin
            errors++;
            $display("FAIL back_to_back: q=%h r=%h z=%b lat=%0d required 0f 0f 0 9",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        send_op(8'hC8, 8'h03, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'h00 || bus.remainder !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b q=%h r=%h required 1 0 00 00",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abandoned_result: out_valid high %0d cycles required 0", seen);
        end
        send_op(8'h09, 8'h02, 1'b0);
        wait_valid(lat);
        checks++;
        if (bus.quotient !== 8'h04 || bus.remainder !== 8'h01 || bus.div_by_zero !== 1'b0 || lat != 9) begin
            errors++;
            $display("FAIL after_reset: q=%h r=%h z=%b lat=%0d required 04 01 0 9",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
        ack();
    endtask

    task automatic test_random();
        logic [7:0] a, b, eq, er;
        logic       s, ez;
        int         lat, mode, exp_lat;
        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 9));
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            if (mode == 0) b = 8'h00;
            if (mode == 1) begin a = 8'h80; b = 8'hFF; end
            if (mode == 2) b = 8'h01;
            model(a, b, s, eq, er, ez);
            exp_lat = ez ? 1 : 9;
            send_op(a, b, s);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++;
            if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez || lat != exp_lat) begin
                errors++;
                $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h z=%b lat=%0d required q=%h r=%h z=%b lat=%0d",
                         n, a, b, s, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er, ez, exp_lat);
            end
            ack();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Iterative restoring divider, the subtract-direction counterpart to the CLA adder in the NPC ALU path.
- Computes quotient and remainder of two DATA_LEN-bit operands, one quotient bit per cycle.
- Operand and result sides each use a valid/ready handshake.
- Serves the M-extension DIV/DIVU/REM/REMU ops; the EXU stalls while it is busy.

Parameters:
DATA_LEN, 8, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  divider can accept operands
dividend  input  DATA_LEN  numerator
divisor  input  DATA_LEN  denominator
is_signed  input  1  1 = two's-complement divide, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DATA_LEN  result quotient
remainder  output  DATA_LEN  result remainder
div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset state: in IDLE. in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0. Counter and shift registers are cleared.
- Reset mid-operation: the current operation is abandoned and no result is produced. The state is IDLE on the next cycle.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- in_ready is 1 only in IDLE.
- Accept: in_valid && in_ready latches dividend, divisor and is_signed. Input values in other cycles are ignored.
- Latching step:
  - Divisor == 0: go directly to DONE. quotient = all ones, remainder = dividend, div_by_zero=1.
  - Otherwise: store |dividend| and |divisor| (absolute values only when is_signed). Record sign_q = sign(dividend)^sign(divisor) and sign_r = sign(dividend). Load counter = DATA_LEN and go to CALC.
- Absolute values:
  - Taken as DATA_LEN-bit unsigned magnitudes, so -2^(DATA_LEN-1) becomes 2^(DATA_LEN-1) unsigned.
  - Working remainder register is DATA_LEN+1 bits wide.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor, computed at DATA_LEN+1 bits.
  - If trial is non-negative: rem = trial and the quotient LSB = 1. Otherwise rem is restored and the quotient LSB = 0.
  - Decrement the counter. When it reaches 0, go to DONE.
- Sign fix-up on entering DONE (signed only): quotient negated if sign_q, remainder negated if sign_r. Results are registered.
- Latency: handshake in cycle 0, out_valid=1 from cycle DATA_LEN+1. For a zero divisor, out_valid=1 from cycle 1.
- DONE: out_valid=1. quotient, remainder and div_by_zero hold stable until out_valid && out_ready.
- After the result handshake: go to IDLE. in_ready rises in the following cycle; there is no same-cycle re-accept.
- Signed overflow (dividend = -2^(DATA_LEN-1), divisor = -1):
  - Falls out of the algorithm naturally.
  - quotient = dividend, remainder = 0, div_by_zero=0. No special case is needed, but the bench must check it.
- Outputs outside DONE: out_valid=0. quotient and remainder keep their last values and are don't-care to consumers.
- div_by_zero is meaningful only while out_valid=1.

Decomposition:
- Shared package:
  - Contains the state encoding enum (DIV_IDLE, DIV_CALC, DIV_DONE) and a localparam for counter width $clog2(DATA_LEN+1).
  - The ALU op codes that map DIV/DIVU/REM/REMU onto is_signed are also placed there.
- One sub-module, div_trial_sub: combinational DATA_LEN+1-bit subtractor.
  - Computed as rem + ~divisor + 1 with carry-lookahead generate/propagate.
  - Outputs difference and borrow; borrow selects restore.
- FSM, counter, magnitude and sign logic live in div_seq.

Test Plan:
- Unsigned 100/7: dividend=0x64, divisor=0x07, is_signed=0 -> quotient=0x0E, remainder=0x02, div_by_zero=0. out_valid exactly 9 cycles after accept.
- Signed -100/7: dividend=0x9C, divisor=0x07, is_signed=1 -> quotient=0xF2 (-14), remainder=0xFE (-2). Also 100/-7 -> quotient=0xF2, remainder=0x02.
- Divide by zero: dividend=0x55, divisor=0x00 (both is_signed values) -> quotient=0xFF, remainder=0x55, div_by_zero=1. out_valid 1 cycle after accept.
- Signed overflow: dividend=0x80, divisor=0xFF, is_signed=1 -> quotient=0x80, remainder=0x00, div_by_zero=0.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and new in_valid is ignored.
  - Raise out_ready -> in_ready=1 the next cycle. A back-to-back second op, 0xFF/0x10 unsigned -> quotient=0x0F, remainder=0x0F.
- Reset mid-CALC: assert rst at cycle 4 of a 200/3 divide -> next cycle in_ready=1, out_valid=0. A fresh 9/2 gives quotient=0x04, remainder=0x01.
